// File: rtl/ff_apb_timer_pkg.sv
// Shared register map, bit positions and address decode for the APB timer.
package ff_apb_timer_pkg;

  localparam logic [15:0] TIMER_CTRL_ADDR     = 16'h0000;
  localparam logic [15:0] TIMER_PRESCALE_ADDR = 16'h0004;
  localparam logic [15:0] TIMER_COMPARE_ADDR  = 16'h0008;
  localparam logic [15:0] TIMER_COUNT_ADDR    = 16'h000C;
  localparam logic [15:0] TIMER_STATUS_ADDR   = 16'h0010;
  localparam logic [15:0] TIMER_ID_ADDR       = 16'h0014;

  localparam int unsigned CTRL_EN_BIT        = 0;
  localparam int unsigned CTRL_ONESHOT_BIT   = 1;
  localparam int unsigned CTRL_IRQEN_BIT     = 2;
  localparam int unsigned STATUS_MATCH_BIT   = 0;
  localparam int unsigned STATUS_RUNNING_BIT = 1;

  typedef enum logic [2:0] {
    RegCtrl,
    RegPrescale,
    RegCompare,
    RegCount,
    RegStatus,
    RegId,
    RegNone
  } reg_sel_e;

  // Byte-lane bits are dropped by the caller; anything outside the map decodes to RegNone.
  function automatic reg_sel_e decode_addr(logic [15:2] word_addr);
    reg_sel_e sel;
    unique case ({word_addr, 2'b00})
      TIMER_CTRL_ADDR:     sel = RegCtrl;
      TIMER_PRESCALE_ADDR: sel = RegPrescale;
      TIMER_COMPARE_ADDR:  sel = RegCompare;
      TIMER_COUNT_ADDR:    sel = RegCount;
      TIMER_STATUS_ADDR:   sel = RegStatus;
      TIMER_ID_ADDR:       sel = RegId;
      default:             sel = RegNone;
    endcase
    return sel;
  endfunction

endpackage

// File: rtl/ff_apb_timer_if.sv
// APB bus signals between a master and the timer slave.
interface ff_apb_timer_if;
  logic [15:0] paddr;
  logic        pwrite;
  logic        psel;
  logic        penable;
  logic [31:0] pwdata;
  logic [31:0] prdata;

  modport master (output paddr, pwrite, psel, penable, pwdata, input prdata);
  modport slave  (input paddr, pwrite, psel, penable, pwdata, output prdata);
endinterface

// File: rtl/ff_prescaler.sv
// Clock-enable divider: tick every div+1 cycles while en is high.
module ff_prescaler #(
  parameter int unsigned W = 16
) (
  input  logic         pclk,
  input  logic         preset,
  input  logic         en,
  input  logic         clr,
  input  logic [W-1:0] div,
  output logic         tick
);

  logic [W-1:0] pcnt_q, pcnt_d;

  assign tick = en & (pcnt_q == div);

  always_comb begin
    pcnt_d = pcnt_q + 1'b1;
    if (!en || clr || tick) pcnt_d = '0;
  end

  always_ff @(posedge pclk) begin
    if (preset) pcnt_q <= '0;
    else        pcnt_q <= pcnt_d;
  end

endmodule

// File: rtl/ff_apb_timer.sv
// APB timer: prescaled 32-bit up-counter with compare, sticky match and level interrupt.
module ff_apb_timer
  import ff_apb_timer_pkg::*;
#(
  parameter int unsigned PRESCALE_W    = 16,
  parameter logic [31:0] RESET_COMPARE = 32'hFFFF_FFFF,
  parameter logic [31:0] ID_VALUE      = 32'h5449_4D31
) (
  input  logic          pclk,
  input  logic          preset,
  ff_apb_timer_if.slave apb,
  output logic          irq
);

  logic [2:0]            ctrl_q, ctrl_d;
  logic [PRESCALE_W-1:0] prescale_q, prescale_d;
  logic [31:0]           compare_q, compare_d;
  logic [31:0]           count_q, count_d;
  logic                  match_q, match_d;
  logic [31:0]           prdata_q, prdata_d;
  logic [31:0]           rdata;
  logic                  setup, wr, count_wr, tick, hit;
  reg_sel_e              sel;
  logic                  unused_addr_lsb;

  assign unused_addr_lsb = ^apb.paddr[1:0];
  assign sel      = decode_addr(apb.paddr[15:2]);
  assign setup    = apb.psel & ~apb.penable;
  assign wr       = apb.psel & apb.penable & apb.pwrite;
  assign count_wr = wr & (sel == RegCount);
  assign hit      = tick & (count_q == compare_q);

  ff_prescaler #(
    .W (PRESCALE_W)
  ) u_prescaler (
    .pclk   (pclk),
    .preset (preset),
    .en     (ctrl_q[CTRL_EN_BIT]),
    .clr    (count_wr),
    .div    (prescale_q),
    .tick   (tick)
  );

  always_comb begin
    rdata = '0;
    unique case (sel)
      RegCtrl:     rdata[2:0] = ctrl_q;
      RegPrescale: rdata[PRESCALE_W-1:0] = prescale_q;
      RegCompare:  rdata = compare_q;
      RegCount:    rdata = count_q;
      RegStatus: begin
        rdata[STATUS_MATCH_BIT]   = match_q;
        rdata[STATUS_RUNNING_BIT] = ctrl_q[CTRL_EN_BIT];
      end
      RegId:       rdata = ID_VALUE;
      default:     rdata = '0;
    endcase
  end

  // Bus writes first, then timer events, so a match set and oneshot clear override the bus.
  always_comb begin
    ctrl_d     = ctrl_q;
    prescale_d = prescale_q;
    compare_d  = compare_q;
    count_d    = count_q;
    match_d    = match_q;
    prdata_d   = prdata_q;
    if (setup) prdata_d = apb.pwrite ? '0 : rdata;
    if (wr) begin
      unique case (sel)
        RegCtrl:     ctrl_d = apb.pwdata[2:0];
        RegPrescale: prescale_d = apb.pwdata[PRESCALE_W-1:0];
        RegCompare:  compare_d = apb.pwdata;
        RegCount:    count_d = apb.pwdata;
        RegStatus:   if (apb.pwdata[STATUS_MATCH_BIT]) match_d = 1'b0;
        default:     ;
      endcase
    end
    if (tick && !count_wr) begin
      if (hit) begin
        count_d = '0;
        match_d = 1'b1;
        if (ctrl_q[CTRL_ONESHOT_BIT]) ctrl_d[CTRL_EN_BIT] = 1'b0;
      end else begin
        count_d = count_q + 32'd1;
      end
    end
  end

  always_ff @(posedge pclk) begin
    if (preset) begin
      ctrl_q     <= '0;
      prescale_q <= '0;
      compare_q  <= RESET_COMPARE;
      count_q    <= '0;
      match_q    <= 1'b0;
      prdata_q   <= '0;
    end else begin
      ctrl_q     <= ctrl_d;
      prescale_q <= prescale_d;
      compare_q  <= compare_d;
      count_q    <= count_d;
      match_q    <= match_d;
      prdata_q   <= prdata_d;
    end
  end

  assign apb.prdata = prdata_q;
  assign irq        = match_q & ctrl_q[CTRL_IRQEN_BIT];

endmodule

// File: tb/tb_ff_apb_timer.sv
// Randomised and directed bench for ff_apb_timer against a cycle-level behavioural model.
module tb_ff_apb_timer;
  import ff_apb_timer_pkg::*;

  localparam int unsigned PW = 16;

  logic pclk = 1'b0;
  logic preset = 1'b1;
  logic irq;
  bit   chk_on = 1'b0;
  int   n_checks = 0;
  int   n_fail = 0;

  ff_apb_timer_if bus ();

  ff_apb_timer #(
    .PRESCALE_W    (PW),
    .RESET_COMPARE (32'hFFFF_FFFF),
    .ID_VALUE      (32'h5449_4D31)
  ) dut (
    .pclk   (pclk),
    .preset (preset),
    .apb    (bus),
    .irq    (irq)
  );

  always #5 pclk = ~pclk;

  // Behavioural model state
  bit [2:0]    m_ctrl;
  bit [31:0]   m_div, m_cmp, m_cnt, m_prdata;
  int unsigned m_pcnt;
  bit          m_match, m_collide, m_w1c_hit;

  function automatic bit [31:0] m_read(bit [15:0] a);
    bit [15:0] wa;
    wa = {a[15:2], 2'b00};
    if (wa == TIMER_CTRL_ADDR)     return {29'd0, m_ctrl};
    if (wa == TIMER_PRESCALE_ADDR) return m_div;
    if (wa == TIMER_COMPARE_ADDR)  return m_cmp;
    if (wa == TIMER_COUNT_ADDR)    return m_cnt;
    if (wa == TIMER_STATUS_ADDR)   return {30'd0, m_ctrl[CTRL_EN_BIT], m_match};
    if (wa == TIMER_ID_ADDR)       return 32'h5449_4D31;
    return 32'd0;
  endfunction

  always @(posedge pclk) begin : model
    bit        tick, hit, wr, cnt_wr;
    bit [2:0]  old_ctrl;
    bit [15:0] wa;
    if (preset) begin
      m_ctrl = 0; m_div = 0; m_cmp = 32'hFFFF_FFFF; m_cnt = 0;
      m_pcnt = 0; m_match = 0; m_prdata = 0;
    end else begin
      old_ctrl = m_ctrl;
      tick   = old_ctrl[CTRL_EN_BIT] && (m_pcnt == m_div);
      hit    = tick && (m_cnt == m_cmp);
      wr     = bus.psel && bus.penable && bus.pwrite;
      wa     = {bus.paddr[15:2], 2'b00};
      cnt_wr = wr && (wa == TIMER_COUNT_ADDR);
      if (bus.psel && !bus.penable) m_prdata = bus.pwrite ? 32'd0 : m_read(bus.paddr);
      if (!old_ctrl[CTRL_EN_BIT] || cnt_wr || tick) m_pcnt = 0;
      else m_pcnt = (m_pcnt + 1) % (1 << PW);
      if (wr) begin
        if (wa == TIMER_CTRL_ADDR)     m_ctrl = bus.pwdata[2:0];
        if (wa == TIMER_PRESCALE_ADDR) m_div = bus.pwdata & ((32'd1 << PW) - 1);
        if (wa == TIMER_COMPARE_ADDR)  m_cmp = bus.pwdata;
        if (wa == TIMER_COUNT_ADDR)    m_cnt = bus.pwdata;
        if (wa == TIMER_STATUS_ADDR && bus.pwdata[0]) begin
          m_match = 0;
          if (hit) m_w1c_hit = 1;
        end
      end
      if (tick && cnt_wr) m_collide = 1;
      if (tick && !cnt_wr) begin
        if (hit) begin
          m_cnt = 0;
          m_match = 1;
          if (old_ctrl[CTRL_ONESHOT_BIT]) m_ctrl[CTRL_EN_BIT] = 0;
        end else begin
          m_cnt = 32'((64'(m_cnt) + 1) % 64'h1_0000_0000);
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(negedge pclk) begin
    if (chk_on) begin
      check("prdata", bus.prdata, m_prdata);
      check("irq", {31'd0, irq}, {31'd0, m_match & m_ctrl[CTRL_IRQEN_BIT]});
    end
  end

  task automatic idle(input int n);
    repeat (n) @(posedge pclk);
    #1;
  endtask

  task automatic apb_write(input logic [15:0] a, input logic [31:0] d);
    bus.psel = 1; bus.penable = 0; bus.pwrite = 1; bus.paddr = a; bus.pwdata = d;
    @(posedge pclk); #1 bus.penable = 1;
    @(posedge pclk); #1 bus.psel = 0; bus.penable = 0;
  endtask

  task automatic apb_read(input logic [15:0] a, output logic [31:0] d);
    bus.psel = 1; bus.penable = 0; bus.pwrite = 0; bus.paddr = a;
    @(posedge pclk); #1 bus.penable = 1;
    d = bus.prdata;
    @(posedge pclk); #1 bus.psel = 0; bus.penable = 0;
  endtask

  task automatic read_check(input string name, input logic [15:0] a, input logic [31:0] exp);
    logic [31:0] d;
    apb_read(a, d);
    check(name, d, exp);
  endtask

  task automatic wait_pcnt(input int unsigned v, input bit need_hit);
    int budget = 200;
    while (!(m_pcnt == v && (!need_hit || m_cnt == m_cmp)) && budget > 0) begin
      idle(1);
      budget--;
    end
    if (budget == 0) check("wait_timeout", 32'd1, 32'd0);
  endtask

  initial begin
    bus.psel = 0; bus.penable = 0; bus.pwrite = 0; bus.paddr = 0; bus.pwdata = 0;
    repeat (3) @(posedge pclk);
    #1 preset = 0;
    chk_on = 1;

    // Reset values
    read_check("rst_ctrl", TIMER_CTRL_ADDR, 32'h0);
    read_check("rst_prescale", TIMER_PRESCALE_ADDR, 32'h0);
    read_check("rst_compare", TIMER_COMPARE_ADDR, 32'hFFFF_FFFF);
    read_check("rst_count", TIMER_COUNT_ADDR, 32'h0);
    read_check("rst_status", TIMER_STATUS_ADDR, 32'h0);
    read_check("rst_id", TIMER_ID_ADDR, 32'h5449_4D31);
    read_check("rst_unmapped", 16'h0020, 32'h0);
    check("rst_irq", {31'd0, irq}, 32'd0);

    // Free-running, div=0, compare=3
    apb_write(TIMER_PRESCALE_ADDR, 32'd0);
    apb_write(TIMER_COMPARE_ADDR, 32'd3);
    apb_write(TIMER_CTRL_ADDR, 32'h5);
    check("pin_cnt_start", m_cnt, 32'd0);
    for (int i = 1; i <= 4; i++) begin
      idle(1);
      check("pin_cnt_step", m_cnt, (i == 4) ? 32'd0 : i);
    end
    check("pin_match4", {31'd0, m_match}, 32'd1);
    check("irq_on_match", {31'd0, irq}, 32'd1);
    apb_write(TIMER_CTRL_ADDR, 32'h4);
    check("irq_held", {31'd0, irq}, 32'd1);
    apb_write(TIMER_STATUS_ADDR, 32'h1);
    check("irq_w1c", {31'd0, irq}, 32'd0);

    // Oneshot, div=4, compare=1
    apb_write(TIMER_CTRL_ADDR, 32'h0);
    apb_write(TIMER_COUNT_ADDR, 32'h0);
    apb_write(TIMER_PRESCALE_ADDR, 32'd4);
    apb_write(TIMER_COMPARE_ADDR, 32'd1);
    apb_write(TIMER_CTRL_ADDR, 32'h3);
    idle(4); check("pin_os_cnt0", m_cnt, 32'd0);
    idle(1); check("pin_os_cnt1", m_cnt, 32'd1);
    idle(4); check("pin_os_cnt1b", m_cnt, 32'd1);
    idle(1); check("pin_os_cnt_wrap", m_cnt, 32'd0);
    check("pin_os_ctrl", {29'd0, m_ctrl}, 32'h2);
    read_check("os_ctrl", TIMER_CTRL_ADDR, 32'h2);
    read_check("os_status", TIMER_STATUS_ADDR, 32'h1);
    idle(20);
    read_check("os_count_stays", TIMER_COUNT_ADDR, 32'h0);

    // COUNT write colliding with a tick
    apb_write(TIMER_STATUS_ADDR, 32'h1);
    apb_write(TIMER_COMPARE_ADDR, 32'd100);
    apb_write(TIMER_CTRL_ADDR, 32'h1);
    m_collide = 0;
    wait_pcnt(3, 0);
    apb_write(TIMER_COUNT_ADDR, 32'h10);
    check("pin_collide", {31'd0, m_collide}, 32'd1);
    read_check("collide_count", TIMER_COUNT_ADDR, 32'h10);
    idle(2); check("pin_collide_hold", m_cnt, 32'h10);
    idle(1); check("pin_collide_next", m_cnt, 32'h11);

    // STATUS W1C landing on the match edge
    apb_write(TIMER_COMPARE_ADDR, 32'h13);
    m_w1c_hit = 0;
    wait_pcnt(3, 1);
    apb_write(TIMER_STATUS_ADDR, 32'h1);
    check("pin_w1c_hit", {31'd0, m_w1c_hit}, 32'd1);
    read_check("w1c_set_wins", TIMER_STATUS_ADDR, 32'h3);

    // 32-bit wrap without match
    apb_write(TIMER_CTRL_ADDR, 32'h0);
    apb_write(TIMER_STATUS_ADDR, 32'h1);
    apb_write(TIMER_PRESCALE_ADDR, 32'd0);
    apb_write(TIMER_COMPARE_ADDR, 32'hFFFF_FFF0);
    apb_write(TIMER_COUNT_ADDR, 32'hFFFF_FFFE);
    apb_write(TIMER_CTRL_ADDR, 32'h1);
    check("pin_wrap_start", m_cnt, 32'hFFFF_FFFE);
    idle(1); check("pin_wrap_ff", m_cnt, 32'hFFFF_FFFF);
    idle(1); check("pin_wrap_zero", m_cnt, 32'h0);
    read_check("wrap_status", TIMER_STATUS_ADDR, 32'h2);
    apb_write(TIMER_CTRL_ADDR, 32'h0);

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      logic [15:0] a;
      logic [31:0] d, rd;
      int kind = $urandom_range(0, 7);
      unique case (kind)
        0: a = TIMER_CTRL_ADDR;
        1: a = TIMER_PRESCALE_ADDR;
        2: a = TIMER_COMPARE_ADDR;
        3: a = TIMER_COUNT_ADDR;
        4: a = TIMER_STATUS_ADDR;
        5: a = TIMER_ID_ADDR;
        6: a = 16'h0018 + 16'($urandom_range(0, 2) * 8);
        default: a = 16'($urandom);
      endcase
      a = a | 16'($urandom_range(0, 3));
      unique case (kind)
        1: d = ($urandom & 32'hFFFF_0000) | $urandom_range(0, 3);
        2, 3: d = $urandom_range(0, 7);
        default: d = $urandom;
      endcase
      if ($urandom_range(0, 9) < 5) apb_write(a, d);
      else apb_read(a, rd);
      idle($urandom_range(0, 3));
    end

    // Reset between setup and access of a COMPARE write
    apb_write(TIMER_CTRL_ADDR, 32'h5);
    bus.psel = 1; bus.penable = 0; bus.pwrite = 1;
    bus.paddr = TIMER_COMPARE_ADDR; bus.pwdata = 32'h55;
    @(posedge pclk); #1 bus.penable = 1; preset = 1;
    @(posedge pclk); #1 preset = 0; bus.psel = 0; bus.penable = 0;
    check("rst_mid_prdata", bus.prdata, 32'h0);
    check("rst_mid_irq", {31'd0, irq}, 32'd0);
    read_check("rst_mid_compare", TIMER_COMPARE_ADDR, 32'hFFFF_FFFF);
    read_check("rst_mid_ctrl", TIMER_CTRL_ADDR, 32'h0);
    read_check("rst_mid_count", TIMER_COUNT_ADDR, 32'h0);
    idle(2);

    chk_on = 0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
